conv_mac_17: RTL and testbench

Four-filter 3×3 convolution MAC stage directly downstream of the weight store. Latches the 36-weight word (4 filters × 9 taps) once it is valid, then accepts one 9-pixel window per input channel over a valid/ready handshake. Accumulates IN_CH windows through a pipelined dot-product datapath and emits four requantized, saturated outputs per run. All values are signed fixed point of width `data_len` with FRAC fractional bits.

---
 rtl/conv_mac_17_pkg.sv | 23 ++
 rtl/conv_mac_17_dot9.sv | 62 ++++++
 rtl/conv_mac_17.sv | 164 ++++++++++++++++
 tb/tb_conv_mac_17.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_17_pkg.sv
// Shared constants and FSM encoding for the conv_mac_17 four-filter 3x3 MAC stage.
// DATA_LEN is the shared sample width; it defaults to 16 when no shared header defines it.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

package conv_mac_17_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_W = 3'd1,
    S_ACC    = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUT    = 3'd4
  } state_t;

  localparam int DW        = `DATA_LEN;
  localparam int N_FILT    = 4;
  localparam int N_TAP     = 9;
  localparam int DRAIN_LEN = 3;
  localparam int DRAIN_W   = 2;

endpackage

// File: rtl/conv_mac_17_dot9.sv
// Nine-tap signed dot product: registered multipliers (stage 1) feeding a registered
// adder tree (stage 2), with a valid bit travelling alongside the data.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module conv_mac_17_dot9
  import conv_mac_17_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [N_TAP*DW-1:0]      w,
  input  logic [N_TAP*DW-1:0]      x,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  sum
);

  localparam int PW = 2 * DW;

  logic [N_TAP*PW-1:0]     prod_flat;
  logic                    v1_reg;
  logic                    v2_reg;
  logic signed [ACC_W-1:0] tree;
  logic signed [ACC_W-1:0] sum_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_TAP; gi++) begin : g_tap
      logic signed [PW-1:0] prod_reg;
      always_ff @(posedge clk) begin
        prod_reg <= $signed(w[gi*DW +: DW]) * $signed(x[gi*DW +: DW]);
      end
      assign prod_flat[gi*PW +: PW] = prod_reg;
    end
  endgenerate

  // Products are sign-extended to the accumulator width before summing.
  always_comb begin
    tree = '0;
    for (int t = 0; t < N_TAP; t++) begin
      tree = tree + ACC_W'($signed(prod_flat[t*PW +: PW]));
    end
  end

  always_ff @(posedge clk) begin
    sum_reg <= tree;
    if (rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      v1_reg <= in_valid;
      v2_reg <= v1_reg;
    end
  end

  assign out_valid = v2_reg;
  assign sum       = sum_reg;

endmodule

// File: rtl/conv_mac_17.sv
// Four-filter 3x3 convolution MAC: weight latch, IN_CH-window accumulation, requantize.
// Optional macro RELU_EN zeroes negative saturated results before the output register.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module conv_mac_17
  import conv_mac_17_pkg::*;
#(
  parameter int IN_CH = 16,
  parameter int FRAC  = 8,
  parameter int ACC_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     w_valid,
  input  logic [N_FILT*N_TAP*DW-1:0] w_q,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic [N_TAP*DW-1:0]      x_data,
  output logic                     y_valid,
  input  logic                     y_ready,
  output logic [N_FILT*DW-1:0]     y_data,
  output logic                     busy
);

  localparam int CW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((64'sd1 <<< (DW - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] Q_MIN = ~Q_MAX;

  state_t               state_reg, state_next;
  logic [CW-1:0]        ch_cnt_reg, ch_cnt_next;
  logic [DRAIN_W-1:0]   drain_cnt_reg, drain_cnt_next;
  logic                 w_load, acc_clear, y_load, y_done;

  logic [N_FILT*N_TAP*DW-1:0] w_reg;
  logic [N_TAP*DW-1:0]  x_data_reg;
  logic                 x_valid_reg;
  logic                 y_valid_reg;
  logic [N_FILT*DW-1:0] y_data_reg;
  logic [N_FILT*DW-1:0] y_pack;

  logic                    sum_valid [N_FILT];
  logic signed [ACC_W-1:0] sum       [N_FILT];

  function automatic logic signed [DW-1:0] requant(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC;
    if (s > Q_MAX) s = Q_MAX;
    else if (s < Q_MIN) s = Q_MIN;
`ifdef RELU_EN
    if (s < 0) s = '0;
`endif
    return s[DW-1:0];
  endfunction

  assign x_ready = (state_reg == S_ACC);
  assign busy    = (state_reg != S_IDLE);
  assign y_valid = y_valid_reg;
  assign y_data  = y_data_reg;

  always_comb begin
    state_next     = state_reg;
    ch_cnt_next    = ch_cnt_reg;
    drain_cnt_next = drain_cnt_reg;
    w_load         = 1'b0;
    acc_clear      = 1'b0;
    y_load         = 1'b0;
    y_done         = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next  = S_WAIT_W;
          acc_clear   = 1'b1;
          ch_cnt_next = '0;
        end
      end
      S_WAIT_W: begin
        if (w_valid) begin
          w_load     = 1'b1;
          state_next = S_ACC;
        end
      end
      S_ACC: begin
        if (x_valid) begin
          if (ch_cnt_reg == CW'(IN_CH - 1)) begin
            state_next     = S_DRAIN;
            ch_cnt_next    = '0;
            drain_cnt_next = DRAIN_W'(DRAIN_LEN - 1);
          end else begin
            ch_cnt_next = ch_cnt_reg + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_reg == '0) state_next = S_OUT;
        else drain_cnt_next = drain_cnt_reg - DRAIN_W'(1);
      end
      S_OUT: begin
        // First OUT cycle captures the settled accumulators; y_valid follows.
        if (!y_valid_reg) begin
          y_load = 1'b1;
        end else if (y_ready) begin
          y_done     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      ch_cnt_reg    <= '0;
      drain_cnt_reg <= '0;
      x_valid_reg   <= 1'b0;
      y_valid_reg   <= 1'b0;
      y_data_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      ch_cnt_reg    <= ch_cnt_next;
      drain_cnt_reg <= drain_cnt_next;
      x_valid_reg   <= x_valid & x_ready;
      if (y_load) begin
        y_valid_reg <= 1'b1;
        y_data_reg  <= y_pack;
      end else if (y_done) begin
        y_valid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_load) w_reg <= w_q;
    if (x_valid & x_ready) x_data_reg <= x_data;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_FILT; gi++) begin : g_filt
      logic signed [ACC_W-1:0] acc_reg;

      conv_mac_17_dot9 #(.ACC_W(ACC_W)) u_dot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (x_valid_reg),
        .w         (w_reg[gi*N_TAP*DW +: N_TAP*DW]),
        .x         (x_data_reg),
        .out_valid (sum_valid[gi]),
        .sum       (sum[gi])
      );

      always_ff @(posedge clk) begin
        if (rst || acc_clear) acc_reg <= '0;
        else if (sum_valid[gi]) acc_reg <= acc_reg + sum[gi];
      end

      assign y_pack[gi*DW +: DW] = requant(acc_reg);
    end
  endgenerate

endmodule

// File: tb/tb_conv_mac_17.sv
// Directed bench for conv_mac_17: one IN_CH=2 and one IN_CH=4 instance share stimulus.
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_conv_mac_17;

  localparam int DW = `DATA_LEN;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start2 = 1'b0, start4 = 1'b0;
  logic w_valid = 1'b0;
  logic [36*DW-1:0] w_q = '0;
  logic x_valid = 1'b0;
  logic [9*DW-1:0] x_data = '0;
  logic y_ready = 1'b0;
  logic x_ready2, x_ready4, y_valid2, y_valid4, busy2, busy4;
  logic [4*DW-1:0] y_data2, y_data4;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  conv_mac_17 #(.IN_CH(2), .FRAC(8), .ACC_W(40)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .w_valid(w_valid), .w_q(w_q),
    .x_valid(x_valid), .x_ready(x_ready2), .x_data(x_data),
    .y_valid(y_valid2), .y_ready(y_ready), .y_data(y_data2), .busy(busy2));

  conv_mac_17 #(.IN_CH(4), .FRAC(8), .ACC_W(40)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .w_valid(w_valid), .w_q(w_q),
    .x_valid(x_valid), .x_ready(x_ready4), .x_data(x_data),
    .y_valid(y_valid4), .y_ready(y_ready), .y_data(y_data4), .busy(busy4));

  typedef struct {
    int sel;
    int w0, w1, w2, w3;
    int px;
    int e0, e1, e2, e3;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int relu(input int e);
`ifdef RELU_EN
    return (e < 0) ? 0 : e;
`else
    return e;
`endif
  endfunction

  function automatic logic [36*DW-1:0] mk_w(input int a, input int b, input int c, input int d);
    logic [36*DW-1:0] r;
    logic [DW-1:0] v [4];
    v[0] = DW'(a); v[1] = DW'(b); v[2] = DW'(c); v[3] = DW'(d);
    for (int f = 0; f < 4; f++)
      for (int t = 0; t < 9; t++) r[(9*f+t)*DW +: DW] = v[f];
    return r;
  endfunction

  function automatic int lane(input logic [4*DW-1:0] y, input int f);
    logic signed [DW-1:0] s;
    s = y[f*DW +: DW];
    return int'(s);
  endfunction

  function automatic logic xr(input int sel);
    return (sel == 2) ? x_ready2 : x_ready4;
  endfunction
  function automatic logic yv(input int sel);
    return (sel == 2) ? y_valid2 : y_valid4;
  endfunction
  function automatic logic bz(input int sel);
    return (sel == 2) ? busy2 : busy4;
  endfunction
  function automatic logic [4*DW-1:0] yd(input int sel);
    return (sel == 2) ? y_data2 : y_data4;
  endfunction

  // One run with weights already valid and back-to-back windows; holds y_ready low for `hold` cycles.
  task automatic run(input int sel, input logic [36*DW-1:0] wq, input int px, input int hold,
                     output int lat, output logic [4*DW-1:0] y);
    int hs;
    int cyc;
    bit seen;
    w_q = wq; w_valid = 1'b1; y_ready = 1'b0;
    x_data = {9{DW'(px)}};
    if (sel == 2) start2 = 1'b1; else start4 = 1'b1;
    tick();
    start2 = 1'b0; start4 = 1'b0;
    hs = 0; cyc = 0; seen = 0;
    while (cyc < 60 && !seen) begin
      if (yv(sel)) seen = 1;
      else begin
        x_valid = (hs < sel);
        if (x_valid && xr(sel)) hs++;
        tick();
        cyc++;
      end
    end
    x_valid = 1'b0;
    if (!seen) chk("run_timeout", 0, 1);
    lat = cyc;
    y = yd(sel);
    for (int c = 0; c < hold; c++) begin
      tick();
      chk("bp_y_valid", int'(yv(sel)), 1);
      chk("bp_y_data_stable", int'(yd(sel) == y), 1);
    end
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    chk("post_hs_busy", int'(bz(sel)), 0);
    chk("post_hs_y_valid", int'(yv(sel)), 0);
  endtask

  initial begin
    vec_t vt[7];
    int lat;
    logic [4*DW-1:0] y;
    int hs, err, n_hs;
    bit seen, pa, po;

    vt[0] = '{2, 256, 256, 256, 256, 256, 4608, 4608, 4608, 4608};
    vt[1] = '{2, 256, -256, 128, 0, 256, 4608, -4608, 2304, 0};
    vt[2] = '{2, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    vt[3] = '{2, 32767, 32767, 32767, 32767, -32767, -32768, -32768, -32768, -32768};
    vt[4] = '{2, 1, -1, 3, 100, -5, -1, 0, -2, -36};
    vt[5] = '{2, 1000, -1000, 40, 7, 1000, 32767, -32768, 2812, 492};
    vt[6] = '{4, 64, 128, -64, 2, 512, 4608, 9216, -4608, 144};

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_x_ready2", int'(x_ready2), 0);
    chk("rst_y_valid2", int'(y_valid2), 0);
    chk("rst_y_data2", int'(y_data2 != '0), 0);
    chk("rst_busy2", int'(busy2), 0);
    chk("rst_x_ready4", int'(x_ready4), 0);
    chk("rst_y_valid4", int'(y_valid4), 0);
    chk("rst_y_data4", int'(y_data4 != '0), 0);
    chk("rst_busy4", int'(busy4), 0);

    for (int i = 0; i < 7; i++) begin
      run(vt[i].sel, mk_w(vt[i].w0, vt[i].w1, vt[i].w2, vt[i].w3), vt[i].px, 0, lat, y);
      $display("vec %0d sel=%0d lat=%0d y=%0d %0d %0d %0d", i, vt[i].sel, lat,
               lane(y, 0), lane(y, 1), lane(y, 2), lane(y, 3));
      chk($sformatf("vec%0d_latency", i), lat, vt[i].sel + 5);
      chk($sformatf("vec%0d_f0", i), lane(y, 0), relu(vt[i].e0));
      chk($sformatf("vec%0d_f1", i), lane(y, 1), relu(vt[i].e1));
      chk($sformatf("vec%0d_f2", i), lane(y, 2), relu(vt[i].e2));
      chk($sformatf("vec%0d_f3", i), lane(y, 3), relu(vt[i].e3));
      repeat (2) tick();
    end

    // Late weights, bubbles on x_valid, and w_q changing after the latch.
    w_valid = 1'b0; w_q = mk_w(0, 0, 0, 0); x_data = {9{DW'(256)}};
    start4 = 1'b1; tick(); start4 = 1'b0;
    err = 0;
    for (int c = 0; c < 5; c++) begin
      if (x_ready4) err++;
      tick();
    end
    chk("late_w_x_ready_low", err, 0);
    w_valid = 1'b1; w_q = mk_w(256, 256, 256, 256);
    tick();
    w_valid = 1'b0; w_q = mk_w(-5, 7, 0, 1);
    chk("late_w_x_ready_high", int'(x_ready4), 1);
    hs = 0; seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      if (y_valid4) seen = 1;
      else begin
        x_valid = (hs < 4) && (c % 2 == 0);
        if (x_valid && x_ready4) hs++;
        tick();
      end
    end
    x_valid = 1'b0;
    chk("bubble_seen_y_valid", int'(seen), 1);
    y = y_data4;
    $display("bubble run y=%0d %0d %0d %0d", lane(y, 0), lane(y, 1), lane(y, 2), lane(y, 3));
    for (int f = 0; f < 4; f++) chk($sformatf("bubble_f%0d", f), lane(y, f), 9216);
    y_ready = 1'b1; tick(); y_ready = 1'b0;
    tick();

    // Backpressure: five cycles with y_ready low in OUT.
    run(2, mk_w(256, 256, 256, 256), 256, 5, lat, y);
    $display("backpressure run lat=%0d y0=%0d", lat, lane(y, 0));
    chk("bp_f0", lane(y, 0), 4608);
    tick();

    // Reset after one of four windows, then a clean run.
    w_q = mk_w(256, 256, 256, 256); w_valid = 1'b1; x_data = {9{DW'(256)}};
    start4 = 1'b1; tick(); start4 = 1'b0;
    tick();
    x_valid = 1'b1; tick(); x_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    $display("mid-ACC reset x_ready=%0d busy=%0d y_valid=%0d", x_ready4, busy4, y_valid4);
    chk("midrst_x_ready", int'(x_ready4), 0);
    chk("midrst_busy", int'(busy4), 0);
    chk("midrst_y_valid", int'(y_valid4), 0);
    run(4, mk_w(256, 256, 256, 256), 256, 0, lat, y);
    $display("post-reset run lat=%0d y=%0d %0d %0d %0d", lat, lane(y, 0), lane(y, 1), lane(y, 2), lane(y, 3));
    for (int f = 0; f < 4; f++) chk($sformatf("postrst_f%0d", f), lane(y, f), 9216);
    tick();

    // start pulses during ACC and OUT must be ignored.
    w_q = mk_w(256, 256, 256, 256); w_valid = 1'b1; y_ready = 1'b1; x_data = {9{DW'(256)}};
    start2 = 1'b1; tick(); start2 = 1'b0;
    hs = 0; n_hs = 0; pa = 0; po = 0; y = '0;
    for (int c = 0; c < 30; c++) begin
      x_valid = (hs < 2);
      start2 = 1'b0;
      if (x_ready2 && !pa) begin start2 = 1'b1; pa = 1; end
      if (busy2 && !x_ready2 && hs == 2 && !po && !y_valid2) begin start2 = 1'b1; po = 1; end
      if (x_valid && x_ready2) hs++;
      if (y_valid2) begin n_hs++; y = y_data2; end
      tick();
    end
    start2 = 1'b0; x_valid = 1'b0; y_ready = 1'b0;
    $display("start-ignore run handshakes=%0d y0=%0d busy=%0d", n_hs, lane(y, 0), busy2);
    chk("start_ignore_handshakes", n_hs, 1);
    chk("start_ignore_f0", lane(y, 0), 4608);
    chk("start_ignore_busy", int'(busy2), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
